// File: rtl/lbist_seq_ctrl.sv
// lbist_seq_ctrl
//   Logic-BIST sequencer. Each run takes N_SEEDS seed/golden pairs from an
//   external source. For every seed it expands the PRPG (LFSR) into N_CHAINS
//   scan-in streams and compacts the scan-outs in a MISR. The run stops early
//   on the first seed whose signature differs from its golden.
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i                starts a run from IDLE or DONE
//   abort_i                synchronous abort to IDLE; wins over everything else
//   seed_req_o             requests the next seed/golden pair
//   seed_valid_i           seed_i/golden_i valid; a transfer is req && valid
//   seed_i, golden_i       PRPG seed and expected signature for the current seed
//   scan_in_o              low N_CHAINS bits of the PRPG, to the core scan inputs
//   scan_out_i             core scan outputs, compacted into the MISR
//   test_en_o              scan enable (1 = shift)
//   test_mode_o            core test mode
//   lbist_en_o             LBIST mux select in the core
//   busy_o, done_o         run in progress / run finished (held until next start)
//   pass_o, fail_seed_o    result, and index of the first failing seed
//   signature_o            live MISR state
module lbist_seq_ctrl #(
  parameter int unsigned       N_CHAINS    = 16,
  parameter int unsigned       CHAIN_LEN   = 24,
  parameter int unsigned       LFSR_W      = 25,
  parameter logic [LFSR_W-1:0] LFSR_POLY   = 25'h1000004,
  parameter int unsigned       MISR_W      = 16,
  parameter logic [MISR_W-1:0] MISR_POLY   = 16'h002D,
  parameter int unsigned       N_SEEDS     = 10,
  parameter int unsigned       PATTERNS    = 200,
  parameter int unsigned       CAPTURE_CYC = 1,
  localparam int unsigned      SEED_W      = (N_SEEDS > 1) ? $clog2(N_SEEDS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                abort_i,
  output logic                seed_req_o,
  input  logic                seed_valid_i,
  input  logic [LFSR_W-1:0]   seed_i,
  input  logic [MISR_W-1:0]   golden_i,
  output logic [N_CHAINS-1:0] scan_in_o,
  input  logic [N_CHAINS-1:0] scan_out_i,
  output logic                test_en_o,
  output logic                test_mode_o,
  output logic                lbist_en_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [SEED_W-1:0]   fail_seed_o,
  output logic [MISR_W-1:0]   signature_o
);

  localparam int unsigned SHIFT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int unsigned WIN_W   = $clog2(PATTERNS + 2);
  localparam int unsigned CAP_W   = (CAPTURE_CYC > 1) ? $clog2(CAPTURE_CYC) : 1;

  localparam logic [SHIFT_W-1:0] SHIFT_LAST = SHIFT_W'(CHAIN_LEN - 1);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(PATTERNS);
  localparam logic [CAP_W-1:0]   CAP_LAST   = CAP_W'(CAPTURE_CYC - 1);
  localparam logic [SEED_W-1:0]  SEED_LAST  = SEED_W'(N_SEEDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED_REQ,
    S_SHIFT,
    S_CAPTURE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [MISR_W-1:0]   misr_q, misr_d;
  logic [MISR_W-1:0]   golden_q, golden_d;
  logic [SHIFT_W-1:0]  shift_cnt_q, shift_cnt_d;
  logic [CAP_W-1:0]    cap_cnt_q, cap_cnt_d;
  logic [WIN_W-1:0]    win_q, win_d;
  logic [SEED_W-1:0]   seed_idx_q, seed_idx_d;
  logic                pass_q, pass_d;
  logic [SEED_W-1:0]   fail_seed_q, fail_seed_d;

  logic [LFSR_W-1:0]   lfsr_step;
  logic [MISR_W-1:0]   misr_step;

  always_comb begin
    lfsr_step = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_POLY)};
    misr_step = (misr_q << 1) ^ (misr_q[MISR_W-1] ? MISR_POLY : '0)
                ^ MISR_W'(scan_out_i);
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    misr_d      = misr_q;
    golden_d    = golden_q;
    shift_cnt_d = shift_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    win_d       = win_q;
    seed_idx_d  = seed_idx_q;
    pass_d      = pass_q;
    fail_seed_d = fail_seed_q;

    if (abort_i) begin
      // The PRPG is cleared so scan_in_o drops to 0; the MISR keeps its value.
      state_d     = S_IDLE;
      lfsr_d      = '0;
      shift_cnt_d = '0;
      cap_cnt_d   = '0;
      win_d       = '0;
      seed_idx_d  = '0;
      pass_d      = 1'b0;
      fail_seed_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_d     = S_SEED_REQ;
            seed_idx_d  = '0;
            pass_d      = 1'b0;
            fail_seed_d = '0;
          end
        end
        S_SEED_REQ: begin
          if (seed_valid_i) begin
            // An all-zero seed would lock the PRPG, so bit 0 is forced.
            lfsr_d      = (seed_i == '0) ? LFSR_W'(1) : seed_i;
            golden_d    = golden_i;
            misr_d      = '0;
            shift_cnt_d = '0;
            cap_cnt_d   = '0;
            win_d       = '0;
            state_d     = S_SHIFT;
          end
        end
        S_SHIFT: begin
          lfsr_d = lfsr_step;
          // Window 0 only flushes whatever the chains held before the seed.
          if (win_q != '0) begin
            misr_d = misr_step;
          end
          if (shift_cnt_q == SHIFT_LAST) begin
            shift_cnt_d = '0;
            state_d     = (win_q == WIN_LAST) ? S_CHECK : S_CAPTURE;
          end else begin
            shift_cnt_d = shift_cnt_q + 1'b1;
          end
        end
        S_CAPTURE: begin
          if (cap_cnt_q == CAP_LAST) begin
            cap_cnt_d = '0;
            win_d     = win_q + 1'b1;
            state_d   = S_SHIFT;
          end else begin
            cap_cnt_d = cap_cnt_q + 1'b1;
          end
        end
        S_CHECK: begin
          if (misr_q != golden_q) begin
            fail_seed_d = seed_idx_q;
            state_d     = S_DONE;
          end else if (seed_idx_q == SEED_LAST) begin
            pass_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            seed_idx_d = seed_idx_q + 1'b1;
            state_d    = S_SEED_REQ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      lfsr_q      <= '0;
      misr_q      <= '0;
      golden_q    <= '0;
      shift_cnt_q <= '0;
      cap_cnt_q   <= '0;
      win_q       <= '0;
      seed_idx_q  <= '0;
      pass_q      <= 1'b0;
      fail_seed_q <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      misr_q      <= misr_d;
      golden_q    <= golden_d;
      shift_cnt_q <= shift_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      win_q       <= win_d;
      seed_idx_q  <= seed_idx_d;
      pass_q      <= pass_d;
      fail_seed_q <= fail_seed_d;
    end
  end

  always_comb begin
    busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
    done_o      = (state_q == S_DONE);
    seed_req_o  = (state_q == S_SEED_REQ);
    test_en_o   = (state_q == S_SHIFT);
    test_mode_o = busy_o;
    lbist_en_o  = busy_o;
    scan_in_o   = lfsr_q[N_CHAINS-1:0];
    pass_o      = pass_q;
    fail_seed_o = fail_seed_q;
    signature_o = misr_q;
  end

endmodule

// File: tb/tb_lbist_seq_ctrl.sv
module tb_lbist_seq_ctrl;

  localparam int unsigned CL      = 3;
  localparam int unsigned CC      = 1;
  localparam int unsigned PT      = 2;
  localparam int unsigned NS      = 2;
  localparam logic [7:0]  LP      = 8'hB8;
  localparam logic [7:0]  MP      = 8'h1D;
  localparam int unsigned WPS     = CL + CC;              // one shift window plus its capture
  localparam int unsigned RUN_LEN = (PT + 1) * CL + PT * CC; // cycles before the check cycle

  logic       clk_i = 1'b0, rst_ni = 1'b0;
  logic       start_i = 1'b0, abort_i = 1'b0, seed_valid_i = 1'b0;
  logic [7:0] seed_i = '0, golden_i = '0;
  logic [3:0] scan_in_o, scan_out_i;
  logic       seed_req_o, test_en_o, test_mode_o, lbist_en_o, busy_o, done_o, pass_o;
  logic [0:0] fail_seed_o;
  logic [7:0] signature_o;

  lbist_seq_ctrl #(
    .N_CHAINS(4), .CHAIN_LEN(CL), .LFSR_W(8), .LFSR_POLY(LP), .MISR_W(8),
    .MISR_POLY(MP), .N_SEEDS(NS), .PATTERNS(PT), .CAPTURE_CYC(CC)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .seed_req_o(seed_req_o), .seed_valid_i(seed_valid_i), .seed_i(seed_i),
    .golden_i(golden_i), .scan_in_o(scan_in_o), .scan_out_i(scan_out_i),
    .test_en_o(test_en_o), .test_mode_o(test_mode_o), .lbist_en_o(lbist_en_o),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .fail_seed_o(fail_seed_o),
    .signature_o(signature_o)
  );

  initial forever #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  // Scan-out source: 0 = constant, 1 = random per cycle, 2 = loopback of scan_in_o
  int         so_mode  = 0;
  logic [3:0] so_const = '0;
  logic [3:0] so_drv   = '0;
  assign scan_out_i = (so_mode == 2) ? scan_in_o : so_drv;
  initial forever begin
    @(posedge clk_i);
    #2;
    so_drv = (so_mode == 1) ? 4'($urandom) : so_const;
  end

  // Abort injector used by the random phase
  int abort_cd = 0;
  bit aborted  = 1'b0;
  bit abort_own = 1'b0;
  initial forever begin
    @(posedge clk_i);
    #2;
    if (abort_own) begin
      abort_i   = 1'b0;
      abort_own = 1'b0;
    end
    if (abort_cd > 0) begin
      abort_cd--;
      if (abort_cd == 0) begin
        abort_i   = 1'b1;
        abort_own = 1'b1;
        aborted   = 1'b1;
      end
    end
  end

  int req_cycles = 0;
  initial forever begin
    @(negedge clk_i);
    if (seed_req_o === 1'b1) req_cycles++;
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LP)};
  endfunction

  function automatic logic [7:0] misr_next(input logic [7:0] m, input logic [3:0] d);
    logic [7:0] r;
    r = {m[6:0], 1'b0};
    if (m[7]) r = r ^ MP;
    return r ^ {4'b0000, d};
  endfunction

  // Signature a seed produces when scan-outs are looped back to scan-ins.
  function automatic logic [7:0] ref_sig(input logic [7:0] seed);
    logic [7:0] l, m;
    l = (seed == 8'h00) ? 8'h01 : seed;
    m = 8'h00;
    for (int w = 0; w <= int'(PT); w++) begin
      for (int c = 0; c < int'(CL); c++) begin
        if (w != 0) m = misr_next(m, l[3:0]);
        l = lfsr_next(l);
      end
    end
    return m;
  endfunction

  // m_t: cycle index since the seed transfer; the check cycle is m_t == RUN_LEN.
  bit         m_busy = 0, m_done = 0, m_pass = 0, m_req = 0, m_run = 0;
  int         m_t = 0, m_seed = 0, m_fail = 0;
  logic [7:0] m_lfsr = '0, m_misr = '0, m_gold = '0;

  initial begin
    logic [3:0] so;
    forever begin
      @(posedge clk_i or negedge rst_ni);
      so = (so_mode == 2) ? m_lfsr[3:0] : so_drv;
      if (!rst_ni) begin
        m_busy = 0; m_done = 0; m_pass = 0; m_req = 0; m_run = 0;
        m_t = 0; m_seed = 0; m_fail = 0; m_lfsr = '0; m_misr = '0; m_gold = '0;
      end else if (abort_i) begin
        m_busy = 0; m_done = 0; m_pass = 0; m_req = 0; m_run = 0;
        m_fail = 0; m_lfsr = '0;
      end else if (!m_busy) begin
        if (start_i) begin
          m_busy = 1; m_done = 0; m_pass = 0; m_fail = 0; m_seed = 0; m_req = 1;
        end
      end else if (m_req) begin
        if (seed_valid_i) begin
          m_lfsr = (seed_i == 8'h00) ? 8'h01 : seed_i;
          m_gold = golden_i;
          m_misr = '0;
          m_req  = 0;
          m_run  = 1;
          m_t    = 0;
        end
      end else if (m_run) begin
        if (m_t == int'(RUN_LEN)) begin
          m_run = 0;
          if (m_misr != m_gold) begin
            m_fail = m_seed; m_busy = 0; m_done = 1;
          end else if (m_seed == int'(NS) - 1) begin
            m_pass = 1; m_busy = 0; m_done = 1;
          end else begin
            m_seed++; m_req = 1;
          end
        end else begin
          if ((m_t % int'(WPS)) < int'(CL)) begin
            if ((m_t / int'(WPS)) != 0) m_misr = misr_next(m_misr, so);
            m_lfsr = lfsr_next(m_lfsr);
          end
          m_t++;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  initial forever begin
    bit exp_te;
    @(negedge clk_i);
    exp_te = m_run && (m_t < int'(RUN_LEN)) && ((m_t % int'(WPS)) < int'(CL));
    chk("seed_req",  seed_req_o,  m_req);
    chk("test_en",   test_en_o,   exp_te);
    chk("test_mode", test_mode_o, m_busy);
    chk("lbist_en",  lbist_en_o,  m_busy);
    chk("busy",      busy_o,      m_busy);
    chk("done",      done_o,      m_done);
    chk("pass",      pass_o,      m_pass);
    chk("fail_seed", fail_seed_o, m_fail);
    chk("scan_in",   scan_in_o,   m_lfsr[3:0]);
    chk("signature", signature_o, m_misr);
  end

  // ---------------- stimulus ----------------
  logic [7:0] seeds [2];
  logic [7:0] golds [2];

  // One run: start, serve seed requests with the given delays, wait for done.
  task automatic run_seeds(input int d0, input int d1);
    int n;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < int'(NS); k++) begin
      n = 0;
      while (!seed_req_o && !done_o && !aborted && n < 100) begin
        tick();
        n++;
      end
      if (n >= 100) begin
        n_cmp++; n_bad++;
        $display("FAIL seed_req_wait: got timeout expected request for seed %0d", k);
        return;
      end
      if (done_o || aborted) break;
      seed_i   = seeds[k];
      golden_i = golds[k];
      repeat ((k == 0) ? d0 : d1) tick();
      seed_valid_i = 1'b1;
      tick();
      seed_valid_i = 1'b0;
      seed_i       = 8'($urandom);
      golden_i     = 8'($urandom);
    end
    n = 0;
    while (!done_o && !aborted && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) begin
      n_cmp++; n_bad++;
      $display("FAIL done_wait: got timeout expected done_o");
    end
  endtask

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: got time limit expected end of test");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    int n;
    repeat (3) tick();
    rst_ni = 1'b1;
    tick();
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_sig",  signature_o, 0);
    chk("rst_scan", scan_in_o, 0);

    // 1: valid together with start, zero scan-out, zero goldens
    so_mode = 0; so_const = 4'h0;
    start_i = 1'b1; seed_valid_i = 1'b1; seed_i = 8'h5A; golden_i = 8'h00;
    n = 0;
    do begin
      tick();
      n++;
      start_i = 1'b0;
    end while (!done_o && n < 100);
    seed_valid_i = 1'b0;
    chk("t1_cycles", n, 27);
    chk("t1_pass", pass_o, 1);
    chk("t1_fail_seed", fail_seed_o, 0);

    // 1b: constant scan-out 4'hF gives signature 8'h58 after six MISR steps
    so_const = 4'hF;
    seeds[0] = 8'h12; seeds[1] = 8'h34; golds[0] = 8'h58; golds[1] = 8'h58;
    repeat (2) tick();
    run_seeds(0, 0);
    chk("t1b_sig", signature_o, 8'h58);
    chk("t1b_pass", pass_o, 1);

    // 2: loopback with model goldens, then a corrupted seed-1 golden
    so_mode = 2;
    seeds[0] = 8'h3C; seeds[1] = 8'h91;
    golds[0] = ref_sig(seeds[0]); golds[1] = ref_sig(seeds[1]);
    run_seeds(0, 0);
    chk("t2_pass", pass_o, 1);
    chk("t2_sig", signature_o, ref_sig(8'h91));
    golds[1] = golds[1] ^ 8'h01;
    run_seeds(0, 0);
    chk("t2_bad_pass", pass_o, 0);
    chk("t2_bad_seed", fail_seed_o, 1);

    // 3: seed 0 golden wrong, only one request ever made
    golds[0] = ref_sig(seeds[0]) ^ 8'h80; golds[1] = ref_sig(seeds[1]);
    req_cycles = 0;
    run_seeds(0, 0);
    repeat (3) tick();
    chk("t3_pass", pass_o, 0);
    chk("t3_seed", fail_seed_o, 0);
    chk("t3_reqs", req_cycles, 1);

    // 4: delayed seed_valid
    golds[0] = ref_sig(seeds[0]);
    req_cycles = 0;
    run_seeds(5, 5);
    chk("t4_reqs", req_cycles, 12);
    chk("t4_sig", signature_o, ref_sig(8'h91));
    chk("t4_pass", pass_o, 1);

    // 5: ignored start mid-run, abort mid-shift, start+abort together
    start_i = 1'b1; tick(); start_i = 1'b0;
    seed_valid_i = 1'b1; seed_i = seeds[0]; golden_i = golds[0];
    tick();
    seed_valid_i = 1'b0;
    tick(); tick();
    start_i = 1'b1; tick(); start_i = 1'b0;
    tick();
    chk("t5_shifting", test_en_o, 1);
    abort_i = 1'b1; tick(); abort_i = 1'b0;
    chk("t5_busy", busy_o, 0);
    chk("t5_test_en", test_en_o, 0);
    chk("t5_test_mode", test_mode_o, 0);
    chk("t5_done", done_o, 0);
    start_i = 1'b1; abort_i = 1'b1; tick(); start_i = 1'b0; abort_i = 1'b0;
    chk("t5_start_abort", busy_o, 0);
    run_seeds(0, 0);
    chk("t5_pass", pass_o, 1);
    chk("t5_sig", signature_o, ref_sig(8'h91));

    // 6: zero seed, then reset in the middle of a capture
    start_i = 1'b1; tick(); start_i = 1'b0;
    seed_valid_i = 1'b1; seed_i = 8'h00; golden_i = 8'h00;
    tick();
    seed_valid_i = 1'b0;
    chk("t6_seed0", scan_in_o, 4'h1);
    tick();
    chk("t6_step1", scan_in_o, 4'h2);
    tick(); tick();
    chk("t6_step3", scan_in_o, 4'h8);
    chk("t6_capture", test_en_o, 0);
    #1 rst_ni = 1'b0;
    #1;
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_mode", test_mode_o, 0);
    chk("t6_rst_lbist", lbist_en_o, 0);
    chk("t6_rst_scan", scan_in_o, 0);
    chk("t6_rst_req", seed_req_o, 0);
    tick(); tick();
    rst_ni = 1'b1;
    tick();

    // Random runs with optional aborts
    for (int it = 0; it < 30; it++) begin
      so_mode  = int'($urandom_range(1, 2));
      seeds[0] = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      seeds[1] = 8'($urandom);
      for (int k = 0; k < 2; k++)
        golds[k] = (so_mode == 2 && $urandom_range(0, 3) != 0) ? ref_sig(seeds[k]) : 8'($urandom);
      aborted = 1'b0;
      if ($urandom_range(0, 3) == 0) abort_cd = int'($urandom_range(1, 30));
      run_seeds(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      abort_cd = 0;
      repeat (2) tick();
      aborted = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
